// File: rtl/demux_router_pkg.sv
// demux_router_pkg: shared constants and width helper for the demux stream router
package demux_router_pkg;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_vr.sv
// sync_fifo_vr: count-tracked FIFO with cleared storage and registered head
module sync_fifo_vr
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [count_w(DEPTH)-1:0] count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/demux_stream_router.sv
// demux_stream_router: steers each accepted word into one of two flow-controlled FIFOs
module demux_stream_router
  import demux_router_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_sel,
  output logic                      out0_valid,
  input  logic                      out0_ready,
  output logic [WIDTH-1:0]          out0_data,
  output logic                      out1_valid,
  input  logic                      out1_ready,
  output logic [WIDTH-1:0]          out1_data,
  output logic [count_w(DEPTH)-1:0] count0,
  output logic [count_w(DEPTH)-1:0] count1
);
  logic full0, full1, empty0, empty1, xfer;
  assign in_ready   = (in_sel == CH1) ? ~full1 : ~full0;
  assign xfer       = in_valid & in_ready;
  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;
  sync_fifo_vr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .push(xfer & (in_sel == CH0)), .pop(out0_ready),
    .din(in_data), .dout(out0_data), .count(count0), .full(full0), .empty(empty0)
  );
  sync_fifo_vr #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push(xfer & (in_sel == CH1)), .pop(out1_ready),
    .din(in_data), .dout(out1_data), .count(count1), .full(full1), .empty(empty1)
  );
endmodule

// File: tb/tb_demux_stream_router.sv
// tb_demux_stream_router: directed scenario tests for the buffered 1-to-2 router
module tb_demux_stream_router;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_sel = 0;
  logic [7:0] in_data = 0, out0_data, out1_data;
  logic out0_valid, out0_ready = 0, out1_valid, out1_ready = 0;
  logic [2:0] count0, count1;
  int tests = 0, fails = 0;

  demux_stream_router #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .count0(count0), .count1(count1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic s);
    in_valid = 1; in_data = d; in_sel = s;
    step();
    in_valid = 0;
  endtask

  task automatic test_reset();
    step();
    tests++; if (out0_valid !== 0 || out1_valid !== 0) begin fails++; $display("FAIL reset_valid: got %b%b want 00", out0_valid, out1_valid); end
    tests++; if (count0 !== 0 || count1 !== 0) begin fails++; $display("FAIL reset_count: got %0d/%0d want 0/0", count0, count1); end
    tests++; if (out0_data !== 0 || out1_data !== 0) begin fails++; $display("FAIL reset_data: got %h/%h want 00/00", out0_data, out1_data); end
    rst = 0;
    step();
    tests++; if (in_ready !== 1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    push(8'hA5, 0);
    tests++; if (out0_valid !== 1 || out0_data !== 8'hA5 || count0 !== 1) begin fails++; $display("FAIL basic_ch0: got v=%b d=%h c=%0d want 1 a5 1", out0_valid, out0_data, count0); end
    tests++; if (out1_valid !== 0) begin fails++; $display("FAIL basic_ch1_idle: got %b want 0", out1_valid); end
    push(8'h5A, 1);
    tests++; if (out1_valid !== 1 || out1_data !== 8'h5A || count1 !== 1 || count0 !== 1) begin fails++; $display("FAIL basic_ch1: got v=%b d=%h c1=%0d c0=%0d want 1 5a 1 1", out1_valid, out1_data, count1, count0); end
    out0_ready = 1; out1_ready = 1;
    step();
    out0_ready = 0; out1_ready = 0;
    tests++; if (count0 !== 0 || count1 !== 0) begin fails++; $display("FAIL basic_drain: got %0d/%0d want 0/0", count0, count1); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) push(8'(i), 0);
    tests++; if (count0 !== 4) begin fails++; $display("FAIL full_count: got %0d want 4", count0); end
    in_valid = 1; in_sel = 0; in_data = 8'h99;
    #1;
    tests++; if (in_ready !== 0) begin fails++; $display("FAIL full_backpressure: got %b want 0", in_ready); end
    step();
    tests++; if (count0 !== 4 || out0_data !== 8'h01) begin fails++; $display("FAIL full_no_write: got c=%0d d=%h want 4 01", count0, out0_data); end
    in_sel = 1; in_data = 8'h77;
    #1;
    tests++; if (in_ready !== 1) begin fails++; $display("FAIL full_other_ready: got %b want 1", in_ready); end
    step();
    in_valid = 0;
    tests++; if (count1 !== 1 || out1_data !== 8'h77 || count0 !== 4) begin fails++; $display("FAIL full_other_write: got c1=%0d d=%h c0=%0d want 1 77 4", count1, out1_data, count0); end
    out0_ready = 1; out1_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      tests++; if (out0_data !== 8'(i)) begin fails++; $display("FAIL full_order: got %h want %h", out0_data, 8'(i)); end
      step();
    end
    out0_ready = 0; out1_ready = 0;
    tests++; if (count0 !== 0 || count1 !== 0) begin fails++; $display("FAIL full_drain: got %0d/%0d want 0/0", count0, count1); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    int idx = 0, popped = 0, cyc = 0;
    logic exp_rdy;
    while ((idx < 12 || q.size() != 0) && cyc < 200) begin
      out1_ready = (cyc % 2 == 0);
      in_valid = (idx < 12); in_sel = 1; in_data = 8'h10 + 8'(idx);
      #1;
      exp_rdy = q.size() < 4;
      tests++; if (in_ready !== exp_rdy || out1_valid !== (q.size() != 0) || count1 !== 3'(q.size())) begin fails++; $display("FAIL wrap_state: got rdy=%b v=%b c=%0d want %b %b %0d", in_ready, out1_valid, count1, exp_rdy, q.size() != 0, q.size()); end
      if (q.size() != 0 && out1_ready) begin
        tests++; if (out1_data !== q[0]) begin fails++; $display("FAIL wrap_order: got %h want %h", out1_data, q[0]); end
        void'(q.pop_front());
        popped++;
      end
      if (in_valid && exp_rdy) begin q.push_back(in_data); idx++; end
      step();
      cyc++;
    end
    in_valid = 0; out1_ready = 0;
    tests++; if (popped != 12 || count1 !== 0) begin fails++; $display("FAIL wrap_complete: got popped=%0d c=%0d want 12 0", popped, count1); end
  endtask

  task automatic test_simul();
    push(8'hC1, 0);
    push(8'hC2, 0);
    in_valid = 1; in_data = 8'hC3; in_sel = 0; out0_ready = 1;
    step();
    in_valid = 0; out0_ready = 0;
    tests++; if (count0 !== 2 || out0_data !== 8'hC2) begin fails++; $display("FAIL simul_pushpop: got c=%0d d=%h want 2 c2", count0, out0_data); end
    out0_ready = 1;
    step();
    tests++; if (count0 !== 1 || out0_data !== 8'hC3) begin fails++; $display("FAIL simul_next: got c=%0d d=%h want 1 c3", count0, out0_data); end
    step();
    out0_ready = 0;
    tests++; if (count0 !== 0) begin fails++; $display("FAIL simul_drain: got %0d want 0", count0); end
  endtask

  task automatic test_stall();
    push(8'hE1, 1);
    push(8'hE2, 1);
    out0_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_sel = 0; in_data = 8'h30 + 8'(i);
      #1;
      tests++; if (out1_valid !== 1 || out1_data !== 8'hE1 || count1 !== 2) begin fails++; $display("FAIL stall_hold: got v=%b d=%h c=%0d want 1 e1 2", out1_valid, out1_data, count1); end
      if (i > 0) begin
        tests++; if (out0_data !== 8'h30 + 8'(i - 1) || count0 !== 1) begin fails++; $display("FAIL stall_ch0: got d=%h c=%0d want %h 1", out0_data, count0, 8'h30 + 8'(i - 1)); end
      end
      step();
    end
    in_valid = 0;
    step();
    out0_ready = 0;
    tests++; if (count0 !== 0) begin fails++; $display("FAIL stall_ch0_drain: got %0d want 0", count0); end
    out1_ready = 1;
    tests++; if (out1_data !== 8'hE1) begin fails++; $display("FAIL stall_first: got %h want e1", out1_data); end
    step();
    tests++; if (out1_data !== 8'hE2 || count1 !== 1) begin fails++; $display("FAIL stall_second: got d=%h c=%0d want e2 1", out1_data, count1); end
    step();
    out1_ready = 0;
    tests++; if (count1 !== 0) begin fails++; $display("FAIL stall_drain: got %0d want 0", count1); end
  endtask

  task automatic test_reset_mid();
    push(8'hAA, 0);
    push(8'hBB, 0);
    push(8'hCC, 0);
    tests++; if (count0 !== 3) begin fails++; $display("FAIL rstmid_fill: got %0d want 3", count0); end
    #2 rst = 1;
    #1;
    tests++; if (out0_valid !== 0 || count0 !== 0 || out0_data !== 8'h00) begin fails++; $display("FAIL rstmid_async: got v=%b c=%0d d=%h want 0 0 00", out0_valid, count0, out0_data); end
    step();
    rst = 0;
    in_sel = 0;
    step();
    tests++; if (in_ready !== 1 || out0_valid !== 0) begin fails++; $display("FAIL rstmid_release: got rdy=%b v=%b want 1 0", in_ready, out0_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_simul();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
- Buffered, handshaked 1-to-2 demultiplexer.
- Each accepted input word is steered by a per-word select bit into one of two independent output FIFOs. Each FIFO drains through its own valid/ready port.
- Sits directly downstream of the combinational 2:1 demux path. It replaces the raw Y0/Y1 fan-out with flow-controlled channels, so one stalled consumer never corrupts or loses data.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, entries per output FIFO; power of two, >=2.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  router can accept a word for the channel named by in_sel.
- in_data  input  WIDTH  upstream word.
- in_sel  input  1  0 routes to channel 0, 1 routes to channel 1; sampled with in_data.
- out0_valid  output  1  channel 0 head word valid.
- out0_ready  input  1  channel 0 consumer accepts.
- out0_data  output  WIDTH  channel 0 head word.
- out1_valid  output  1  channel 1 head word valid.
- out1_ready  input  1  channel 1 consumer accepts.
- out1_data  output  WIDTH  channel 1 head word.
- count0  output  $clog2(DEPTH)+1  channel 0 occupancy, range 0..DEPTH.
- count1  output  $clog2(DEPTH)+1  channel 1 occupancy, range 0..DEPTH.

Behaviour:
- Reset (async assert, sync-safe release):
  - all pointers and counts go to 0; outN_valid=0.
  - FIFO storage clears to 0, so outN_data=0.
  - in_ready reflects empty FIFOs (1) once reset has been applied.
- Input handshake:
  - in_ready = ~full[in_sel], combinational from in_sel and registered state only. It never depends on outN_ready; there is no full-FIFO bypass.
  - Transfer occurs when in_valid & in_ready at a rising edge. The word is written to FIFO[in_sel] and countN increments.
  - in_valid=0 means no write, whatever in_sel is.
- Output handshake:
  - outN_valid = (countN != 0). outN_data = storage[rd_ptrN], combinational from registers.
  - A pop occurs when outN_valid & outN_ready at a rising edge. rd_ptrN advances and countN decrements.
  - outN_ready while outN_valid=0 has no effect.
- Latency: a word accepted at edge N is visible on outN_valid/outN_data after edge N (one-cycle latency). Channel order is preserved per channel (FIFO).
- Simultaneous events:
  - Push and pop on the same channel in one cycle: count unchanged and both pointers advance. This is legal only when count is 1..DEPTH-1, because full blocks push and empty blocks pop.
  - Push to one channel and pop from the other: the two are independent.
- Wrap-around: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decoded from countN, not from pointer equality.
- Full: countN==DEPTH. in_ready=0 whenever in_sel==N; the other channel may still accept.
- Reset mid-operation: all buffered words are discarded immediately and asynchronously; valid outputs drop in the same cycle.
- Output data must remain stable while outN_valid=1 and outN_ready=0.

Decomposition:
- Shared package `demux_router_pkg`:
  - localparam function for count width ($clog2(DEPTH)+1).
  - channel index constants CH0=1'b0, CH1=1'b1.
- One sub-module, `sync_fifo_vr`: a parameterised WIDTH/DEPTH FIFO with push/pop, count, full, empty and head data. It is instantiated twice.
- The top level holds only select steering, the in_ready mux and port wiring.

Test Plan (WIDTH=8, DEPTH=4):
- Reset check: assert rst mid-run with 3 words in ch0 -> out0_valid=0, count0=0, out0_data=0 immediately; after release in_ready=1.
- Basic routing: send 8'hA5 sel=0, then 8'h5A sel=1, both outN_ready=0 -> out0_data=A5, out1_data=5A one cycle after each accept; count0=1, count1=1.
- Full/backpressure: push 8'h01..8'h04 to ch0 with out0_ready=0 -> count0=4; next in_valid with sel=0 sees in_ready=0; the same cycle with sel=1 sees in_ready=1 and 8'h77 lands in ch1.
- Ordering and wrap-around: continuous push of 8'h10..8'h1B to ch1 with out1_ready toggling 1,0,1,0 -> pops appear in exact order 10..1B; count1 never exceeds 4; pointers wrap at least twice.
- Simultaneous push/pop: ch0 holding 2 words, push 8'hC3 while out0_ready=1 -> count0 stays 2; head advances to the second word; C3 emerges after it.
- Stall stability: out1_valid=1 with out1_ready=0 held for 5 cycles while ch0 traffic runs -> out1_data constant; no ch1 word lost.
